// File: rtl/expr_recognizer.sv
// expr_recognizer: streaming checker for arithmetic expressions with multi-digit
// operands, nested parentheses, sticky error code and operand counting.
module expr_recognizer #(
    parameter int W          = 8,
    parameter int MAX_DIGITS = 4,
    parameter int MAX_DEPTH  = 3,
    parameter int CNT_W      = 8,
    localparam int DEPTH_W   = (MAX_DEPTH > 0) ? $clog2(MAX_DEPTH + 1) : 1,
    localparam int DCNT_W    = (MAX_DIGITS > 1) ? $clog2(MAX_DIGITS + 1) : 1
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               restart,
    input  logic               in_valid,
    input  logic [W-1:0]       in,
    output logic               out,
    output logic               err,
    output logic [2:0]         err_code,
    output logic [DEPTH_W-1:0] depth,
    output logic [CNT_W-1:0]   num_cnt
);
    typedef enum logic [1:0] {START, NUM, CLOSE, ERR} state_t;

    localparam logic [DEPTH_W-1:0] DEPTH_MAX = DEPTH_W'(MAX_DEPTH);
    localparam logic [DCNT_W-1:0]  DIG_MAX   = DCNT_W'(MAX_DIGITS);
    localparam logic [CNT_W-1:0]   CNT_SAT   = '1;

    state_t             state, state_n;
    logic [DCNT_W-1:0]  dcnt, dcnt_n;
    logic [DEPTH_W-1:0] depth_n;
    logic [CNT_W-1:0]   cnt_n;
    logic [2:0]         code_n;
    logic               high, is_digit, is_op, is_lp, is_rp;
    logic [6:0]         c;

    // Any set bit above the 7-bit ASCII range makes the character illegal.
    if (W > 7) begin : g_high
        assign high = |in[W-1:7];
    end else begin : g_nohigh
        assign high = 1'b0;
    end

    assign c        = in[6:0];
    assign is_digit = !high && c >= 7'h30 && c <= 7'h39;
    assign is_op    = !high && (c == 7'h2B || c == 7'h2D || c == 7'h2A || c == 7'h2F);
    assign is_lp    = !high && c == 7'h28;
    assign is_rp    = !high && c == 7'h29;

    always_comb begin
        state_n = state;
        dcnt_n  = dcnt;
        depth_n = depth;
        cnt_n   = num_cnt;
        code_n  = err_code;
        case (state)
            START: begin
                if (is_digit) begin
                    state_n = NUM;
                    dcnt_n  = DCNT_W'(1);
                    cnt_n   = (num_cnt == CNT_SAT) ? num_cnt : num_cnt + 1'b1;
                end else if (is_lp && depth < DEPTH_MAX) begin
                    depth_n = depth + 1'b1;
                end else begin
                    state_n = ERR;
                    code_n  = is_lp ? 3'd4 : 3'd1;
                end
            end
            NUM, CLOSE: begin
                if (is_digit && state == NUM && dcnt < DIG_MAX) begin
                    dcnt_n = dcnt + 1'b1;
                end else if (is_op) begin
                    state_n = START;
                end else if (is_rp && depth != '0) begin
                    state_n = CLOSE;
                    depth_n = depth - 1'b1;
                end else begin
                    state_n = ERR;
                    code_n  = is_rp ? 3'd3 : (is_digit && state == NUM) ? 3'd2 : 3'd1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state    <= START;
            dcnt     <= '0;
            depth    <= '0;
            num_cnt  <= '0;
            err_code <= '0;
        end else if (restart) begin
            state    <= START;
            dcnt     <= '0;
            depth    <= '0;
            num_cnt  <= '0;
            err_code <= '0;
        end else if (in_valid) begin
            state    <= state_n;
            dcnt     <= dcnt_n;
            depth    <= depth_n;
            num_cnt  <= cnt_n;
            err_code <= code_n;
        end
    end

    assign err = state == ERR;
    assign out = (state == NUM || state == CLOSE) && depth == '0;
endmodule

// File: tb/tb_expr_recognizer.sv
// tb_expr_recognizer: directed and randomized checks of expr_recognizer against
// a model that re-scans the whole accepted character history each cycle.
module tb_expr_recognizer;
    localparam int W = 8, MD = 4, MP = 3, CW = 8;

    logic          clk = 0, clr = 0, restart = 0, in_valid = 0;
    logic [W-1:0]  in = '0;
    logic          out, err;
    logic [2:0]    err_code;
    logic [1:0]    depth;
    logic [CW-1:0] num_cnt;
    int            tests = 0, fails = 0;
    byte unsigned  hist[$];

    expr_recognizer #(.W(W), .MAX_DIGITS(MD), .MAX_DEPTH(MP), .CNT_W(CW)) dut (
        .clk(clk), .clr(clr), .restart(restart), .in_valid(in_valid), .in(in),
        .out(out), .err(err), .err_code(err_code), .depth(depth), .num_cnt(num_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit isd(input byte unsigned ch);
        return ch >= 8'h30 && ch <= 8'h39;
    endfunction

    function automatic bit isop(input byte unsigned ch);
        return ch == 8'h2B || ch == 8'h2D || ch == 8'h2A || ch == 8'h2F;
    endfunction

    // Judges the accepted text by looking at each character and its predecessor.
    function automatic void model(output int o, output int e, output int d, output int n);
        int code = 0, dep = 0, cnt = 0, run = 0;
        byte unsigned p = 0;
        bit first = 1;
        foreach (hist[i]) begin
            byte unsigned ch = hist[i];
            bit want_opnd = first || isop(p) || p == 8'h28;
            bit after_val = !first && (isd(p) || p == 8'h29);
            if (code != 0) break;
            if (isd(ch)) begin
                if (want_opnd) begin
                    cnt = (cnt == (1 << CW) - 1) ? cnt : cnt + 1;
                    run = 1;
                end else if (isd(p) && run < MD) run++;
                else code = isd(p) ? 2 : 1;
            end else if (ch == 8'h28) begin
                if (!want_opnd) code = 1;
                else if (dep == MP) code = 4;
                else dep++;
            end else if (ch == 8'h29) begin
                if (!after_val) code = 1;
                else if (dep == 0) code = 3;
                else dep--;
            end else if (isop(ch)) begin
                if (!after_val) code = 1;
            end else code = 1;
            p = ch;
            first = 0;
        end
        e = code;
        d = dep;
        n = cnt;
        o = (code == 0 && !first && (isd(p) || p == 8'h29) && dep == 0) ? 1 : 0;
    endfunction

    task automatic compare(input string tag);
        int o, e, d, n;
        model(o, e, d, n);
        check({tag, " out"}, 32'(out), o);
        check({tag, " err"}, 32'(err), (e != 0) ? 1 : 0);
        check({tag, " code"}, 32'(err_code), e);
        check({tag, " depth"}, 32'(depth), d);
        check({tag, " num_cnt"}, 32'(num_cnt), n);
    endtask

    task automatic step(input bit v, input byte unsigned ch, input bit rs, input string tag);
        in_valid = v;
        in = ch;
        restart = rs;
        @(posedge clk);
        if (rs) hist.delete();
        else if (v) hist.push_back(ch);
        #1;
        compare(tag);
        restart = 0;
        in_valid = 0;
    endtask

    task automatic send(input string s, input string tag);
        foreach (s[i]) step(1, s[i], 0, tag);
    endtask

    byte unsigned alpha[] = '{8'h30, 8'h31, 8'h32, 8'h35, 8'h39, 8'h31, 8'h37,
                              8'h2B, 8'h2D, 8'h2A, 8'h2F, 8'h28, 8'h28, 8'h29,
                              8'h29, 8'h20, 8'h61, 8'hB1};

    initial begin
        #12;
        check("reset out", 32'(out), 0);
        check("reset err", 32'(err), 0);
        check("reset num_cnt", 32'(num_cnt), 0);
        clr = 1;

        send("12+3", "t1");
        check("t1 num_cnt", 32'(num_cnt), 2);
        step(0, 0, 1, "t2 restart");
        send("12345", "t2");
        check("t2 code", 32'(err_code), 2);
        send("+7(", "t2 absorb");
        check("t2 frozen cnt", 32'(num_cnt), 1);
        step(0, 0, 1, "t3 restart");
        send("(1+2)*3", "t3");
        check("t3 out", 32'(out), 1);
        check("t3 num_cnt", 32'(num_cnt), 3);
        step(0, 0, 1, "t4 restart");
        send("((((", "t4");
        check("t4 code", 32'(err_code), 4);
        check("t4 depth", 32'(depth), 3);
        step(0, 0, 1, "t4b restart");
        send("1)", "t4b");
        check("t4b code", 32'(err_code), 3);
        step(0, 0, 1, "t5 restart");
        send("+", "t5");
        check("t5 code", 32'(err_code), 1);
        step(0, 0, 1, "t5b restart");
        send("1", "t5b");
        for (int i = 0; i < 5; i++) step(0, 8'h2B, 0, "t5b gap");
        check("t5b gap out", 32'(out), 1);
        send("+", "t5b");
        check("t5b out", 32'(out), 0);

        step(0, 0, 1, "t6 restart");
        send("(12", "t6");
        #2 clr = 0;
        #1;
        hist.delete();
        compare("t6 async");
        clr = 1;
        send("(1", "t6b");
        step(1, 8'h35, 1, "t6b restart+valid");

        for (int i = 0; i < 256; i++) send("1+", "sat");
        send("1", "sat");
        check("sat num_cnt", 32'(num_cnt), 255);

        for (int i = 0; i < 3000; i++) begin
            int r = int'($urandom_range(0, 99));
            step(r < 80, alpha[$urandom_range(0, alpha.size() - 1)], r < 4, "rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
